// File: rtl/mem_arb.sv
// Two-master round-robin arbiter for the data RAM read/write ports.
// Optional bus lock with timeout is enabled by defining MEM_ARB_LOCK_EN.
module mem_arb #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [2:0]  m0_size,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [2:0]  m1_size,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] rd_addr_o,
  output logic        rd_en_o,
  output logic [2:0]  rd_size_o,
  input  logic [31:0] rd_data_i,
  output logic [31:0] wd_addr_o,
  output logic        wd_en_o,
  output logic [2:0]  wd_size_o,
  output logic [31:0] wd_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  rv_q, rv_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;

  logic        r0, r1, any, sel;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  logic        legal, rd_go, wr_go, tmo;

  // Eligible requesters, round-robin winner and its transaction fields.
  always_comb begin
    r0      = m0_req && (state_q != LOCK1);
    r1      = m1_req && (state_q != LOCK0);
    any     = r0 || r1;
    sel     = (r0 && r1) ? ~last_q : r1;
    s_we    = sel ? m1_we    : m0_we;
    s_addr  = sel ? m1_addr  : m0_addr;
    s_size  = sel ? m1_size  : m0_size;
    s_wdata = sel ? m1_wdata : m0_wdata;
  end

  // Size must be byte/half/word and the address aligned to it.
  always_comb begin
    legal = 1'b0;
    unique case (s_size)
      3'd1:    legal = 1'b1;
      3'd2:    legal = ~s_addr[0];
      3'd4:    legal = (s_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Grants and RAM port drive; ports are zero when not enabled.
  always_comb begin
    m0_gnt    = any && !sel;
    m1_gnt    = any && sel;
    rd_go     = any && legal && !s_we;
    wr_go     = any && legal && s_we;
    rd_en_o   = rd_go;
    wd_en_o   = wr_go;
    rd_addr_o = rd_go ? s_addr  : '0;
    rd_size_o = rd_go ? s_size  : '0;
    wd_addr_o = wr_go ? s_addr  : '0;
    wd_size_o = wr_go ? s_size  : '0;
    wd_data_o = wr_go ? s_wdata : '0;
  end

`ifdef MEM_ARB_LOCK_EN
  logic own_req, own_lock, s_lock;

  // Lock FSM: entry on a legal locked grant, release or timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo      = 1'b0;
    s_lock   = sel ? m1_lock : m0_lock;
    own_req  = (state_q == LOCK1) ? m1_req  : m0_req;
    own_lock = (state_q == LOCK1) ? m1_lock : m0_lock;
    unique case (state_q)
      IDLE: begin
        if (any && legal && s_lock) begin
          state_d = sel ? LOCK1 : LOCK0;
          cnt_d   = '0;
        end
      end
      LOCK0, LOCK1: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(LOCK_MAX - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (any && !s_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!own_req && !own_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock ^ cnt_q[0];

  // Without lock support the arbiter never leaves IDLE.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    tmo     = 1'b0;
  end
`endif

  // Next values for round-robin pointer, read return and error pulses.
  always_comb begin
    last_d = any ? sel : last_q;
    rv_d   = {m1_gnt && rd_go, m0_gnt && rd_go};
    err_d  = {m1_gnt && !legal, m0_gnt && !legal};
    err_d  = err_d | {tmo && (state_q == LOCK1),
                      tmo && (state_q == LOCK0)};
    rd0_d  = (m0_gnt && rd_go) ? rd_data_i : rd0_q;
    rd1_d  = (m1_gnt && rd_go) ? rd_data_i : rd1_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv_q    <= '0;
      err_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign m0_rvalid = rv_q[0];
  assign m1_rvalid = rv_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table, random traffic
// against a transaction-level model, and directed reset/lock cases.
module tb_mem_arb;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    txn_t        a;
    txn_t        b;
    logic [1:0]  g;
    logic        rd;
    logic        wd;
    logic [31:0] ad;
    logic [31:0] wdat;
    logic [1:0]  err;
    logic [1:0]  rv;
    logic [31:0] rdat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  txn_t t0, t1;

  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] rd_addr_o, rd_data_i, wd_addr_o, wd_data_o;
  logic        rd_en_o, wd_en_o;
  logic [2:0]  rd_size_o, wd_size_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rd_data_i = mem_val(rd_addr_o);

  mem_arb #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(t0.req), .m0_we(t0.we), .m0_addr(t0.addr),
    .m0_size(t0.size), .m0_wdata(t0.wdata), .m0_lock(t0.lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(t1.req), .m1_we(t1.we), .m1_addr(t1.addr),
    .m1_size(t1.size), .m1_wdata(t1.wdata), .m1_lock(t1.lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .rd_addr_o(rd_addr_o), .rd_en_o(rd_en_o), .rd_size_o(rd_size_o),
    .rd_data_i(rd_data_i),
    .wd_addr_o(wd_addr_o), .wd_en_o(wd_en_o), .wd_size_o(wd_size_o),
    .wd_data_o(wd_data_o)
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endfunction

  function automatic txn_t mk(logic we, logic [31:0] a, logic [2:0] s,
                              logic [31:0] d, logic lk);
    txn_t t;
    t.req = 1'b1; t.we = we; t.addr = a;
    t.size = s; t.wdata = d; t.lock = lk;
    return t;
  endfunction

  function automatic txn_t rd(logic [31:0] a, logic [2:0] s);
    return mk(1'b0, a, s, 32'h0, 1'b0);
  endfunction

  function automatic txn_t wr(logic [31:0] a, logic [31:0] d);
    return mk(1'b1, a, 3'd4, d, 1'b0);
  endfunction

  function automatic vec_t row(txn_t a, txn_t b, logic [1:0] g,
                               logic r, logic w, logic [31:0] ad,
                               logic [31:0] wdat, logic [1:0] err,
                               logic [1:0] rv, logic [31:0] rdat);
    vec_t v;
    v.a = a; v.b = b; v.g = g; v.rd = r; v.wd = w; v.ad = ad;
    v.wdat = wdat; v.err = err; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  // Legal access: byte/half/word size and address a multiple of it.
  function automatic logic ok_acc(logic [31:0] a, logic [2:0] s);
    if (s == 3'd1) return 1'b1;
    if (s == 3'd2) return (a % 2) == 0;
    if (s == 3'd4) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.req   = ($urandom_range(0, 3) != 0);
    t.we    = 1'($urandom_range(0, 1));
    t.lock  = 1'b0;
    t.addr  = 32'($urandom_range(0, 255));
    t.wdata = $urandom;
    case ($urandom_range(0, 7))
      0, 1:    t.size = 3'd1;
      2, 3:    t.size = 3'd2;
      4, 5:    t.size = 3'd4;
      6:       t.size = 3'd3;
      default: t.size = 3'd0;
    endcase
    return t;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    t0 = '0;
    t1 = '0;
    adv();
    rst = 1'b0;
  endtask

  task automatic go(txn_t a, txn_t b);
    t0 = a;
    t1 = b;
    @(negedge clk);
  endtask

  vec_t vt[16];
  vec_t pv;
  txn_t cur[2];
  txn_t x;
  int   w, mlast;
  logic lg;
  logic [1:0]  mrv, merr, mg;
  logic [31:0] mrd[2];

  initial begin
    rst = 1'b1;
    t0 = '0;
    t1 = '0;
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rst gnt", {m1_gnt, m0_gnt}, 0);
    chk("rst rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("rst err", {m1_err, m0_err}, 0);
    chk("rst rdata0", m0_rdata, 0);
    chk("rst rdata1", m1_rdata, 0);
    chk("rst ram en", {rd_en_o, wd_en_o}, 0);
    chk("rst ram addr", rd_addr_o | wd_addr_o | wd_data_o, 0);
    adv();

    vt[0]  = row(wr(32'h40, 32'hA0A0A0A0), wr(32'h44, 32'hB1B1B1B1),
                 2'b01, 0, 1, 32'h40, 32'hA0A0A0A0, 0, 0, 0);
    vt[1]  = row(wr(32'h48, 32'hC2C2C2C2), wr(32'h44, 32'hB1B1B1B1),
                 2'b10, 0, 1, 32'h44, 32'hB1B1B1B1, 0, 0, 0);
    vt[2]  = row(wr(32'h48, 32'hC2C2C2C2), wr(32'h4C, 32'hD3D3D3D3),
                 2'b01, 0, 1, 32'h48, 32'hC2C2C2C2, 0, 0, 0);
    vt[3]  = row(wr(32'h50, 32'hE4E4E4E4), wr(32'h4C, 32'hD3D3D3D3),
                 2'b10, 0, 1, 32'h4C, 32'hD3D3D3D3, 0, 0, 0);
    vt[4]  = row(rd(32'h10, 3'd4), '0,
                 2'b01, 1, 0, 32'h10, 0, 0, 2'b01, 32'hDEADBEEF);
    vt[5]  = row('0, '0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    vt[6]  = row('0, wr(32'h13, 32'h12345678),
                 2'b10, 0, 0, 0, 0, 2'b10, 0, 0);
    vt[7]  = row('0, '0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    vt[8]  = row(rd(32'h8, 3'd3), '0,
                 2'b01, 0, 0, 0, 0, 2'b01, 0, 0);
    vt[9]  = row('0, '0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    vt[10] = row('0, rd(32'h22, 3'd2),
                 2'b10, 1, 0, 32'h22, 0, 0, 2'b10, mem_val(32'h22));
    vt[11] = row(rd(32'h5, 3'd1), rd(32'h30, 3'd4),
                 2'b01, 1, 0, 32'h5, 0, 0, 2'b01, mem_val(32'h5));
    vt[12] = row('0, rd(32'h30, 3'd4),
                 2'b10, 1, 0, 32'h30, 0, 0, 2'b10, mem_val(32'h30));
    vt[13] = row(rd(32'h14, 3'd4), '0,
                 2'b01, 1, 0, 32'h14, 0, 0, 2'b01, mem_val(32'h14));
    vt[14] = row(rd(32'h18, 3'd4), '0,
                 2'b01, 1, 0, 32'h18, 0, 0, 2'b01, mem_val(32'h18));
    vt[15] = row('0, '0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    pv = '0;
    for (int i = 0; i < 16; i++) begin
      go(vt[i].a, vt[i].b);
      chk($sformatf("row%0d gnt", i), {m1_gnt, m0_gnt}, vt[i].g);
      chk($sformatf("row%0d rd_en", i), rd_en_o, vt[i].rd);
      chk($sformatf("row%0d wd_en", i), wd_en_o, vt[i].wd);
      if (vt[i].rd)
        chk($sformatf("row%0d rd_addr", i), rd_addr_o, vt[i].ad);
      if (vt[i].wd) begin
        chk($sformatf("row%0d wd_addr", i), wd_addr_o, vt[i].ad);
        chk($sformatf("row%0d wd_data", i), wd_data_o, vt[i].wdat);
      end
      chk($sformatf("row%0d err", i), {m1_err, m0_err}, pv.err);
      chk($sformatf("row%0d rvalid", i), {m1_rvalid, m0_rvalid}, pv.rv);
      if (pv.rv[0]) chk($sformatf("row%0d rdata0", i), m0_rdata, pv.rdat);
      if (pv.rv[1]) chk($sformatf("row%0d rdata1", i), m1_rdata, pv.rdat);
      pv = vt[i];
      adv();
    end

    do_reset();
    mlast = 1; mrv = '0; merr = '0; mg = '0;
    mrd[0] = '0; mrd[1] = '0;
    cur[0] = '0; cur[1] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++)
        if (!cur[n].req || mg[n]) cur[n] = rnd_txn();
      go(cur[0], cur[1]);
      w = -1;
      if (cur[0].req && cur[1].req) w = (mlast == 1) ? 0 : 1;
      else if (cur[0].req) w = 0;
      else if (cur[1].req) w = 1;
      x  = (w == 1) ? cur[1] : cur[0];
      lg = ok_acc(x.addr, x.size);
      chk("rnd gnt0", m0_gnt, w == 0);
      chk("rnd gnt1", m1_gnt, w == 1);
      chk("rnd rd_en", rd_en_o, (w >= 0) && lg && !x.we);
      chk("rnd wd_en", wd_en_o, (w >= 0) && lg && x.we);
      if (rd_en_o) begin
        chk("rnd rd_addr", rd_addr_o, x.addr);
        chk("rnd rd_size", rd_size_o, x.size);
      end
      if (wd_en_o) begin
        chk("rnd wd_addr", wd_addr_o, x.addr);
        chk("rnd wd_size", wd_size_o, x.size);
        chk("rnd wd_data", wd_data_o, x.wdata);
      end
      chk("rnd rvalid", {m1_rvalid, m0_rvalid}, mrv);
      chk("rnd err", {m1_err, m0_err}, merr);
      chk("rnd rdata0", m0_rdata, mrd[0]);
      chk("rnd rdata1", m1_rdata, mrd[1]);
      mrv = '0; merr = '0; mg = '0;
      if (w >= 0) begin
        mlast = w;
        mg[w] = 1'b1;
        if (!lg) merr[w] = 1'b1;
        else if (!x.we) begin
          mrv[w] = 1'b1;
          mrd[w] = mem_val(x.addr);
        end
      end
      adv();
    end

    // Reset with a read in flight: rvalid dropped, pointer back to m1.
    do_reset();
    go(rd(32'h10, 3'd4), '0);
    adv();
    rst = 1'b1;
    go(rd(32'h14, 3'd4), '0);
    chk("rstA gnt0", m0_gnt, 1);
    adv();
    rst = 1'b0;
    go(rd(32'h18, 3'd4), rd(32'h1C, 3'd4));
    chk("rstA rvalid0", m0_rvalid, 0);
    chk("rstA rdata0", m0_rdata, 0);
    chk("rstA conflict", {m1_gnt, m0_gnt}, 2'b01);
    adv();

`ifdef MEM_ARB_LOCK_EN
    do_reset();
    go(mk(1'b0, 32'h20, 3'd4, 0, 1'b1), wr(32'h60, 32'h11));
    chk("lock enter", {m1_gnt, m0_gnt}, 2'b01);
    adv();
    go(wr(32'h20, 32'h55), wr(32'h60, 32'h11));
    chk("lock hold", {m1_gnt, m0_gnt}, 2'b01);
    chk("lock wr", wd_en_o, 1);
    chk("lock rvalid0", m0_rvalid, 1);
    adv();
    go('0, wr(32'h60, 32'h11));
    chk("lock release", {m1_gnt, m0_gnt}, 2'b10);
    adv();

    do_reset();
    go(mk(1'b0, 32'h20, 3'd4, 0, 1'b1), '0);
    chk("tmo enter", m0_gnt, 1);
    adv();
    x = '0;
    x.lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      go(x, wr(32'h64, 32'h22));
      chk($sformatf("tmo wait%0d gnt1", k), m1_gnt, 0);
      chk($sformatf("tmo wait%0d err0", k), m0_err, 0);
      adv();
    end
    go(x, wr(32'h64, 32'h22));
    chk("tmo gnt1", m1_gnt, 1);
    chk("tmo err0", m0_err, 1);
    adv();
    go('0, '0);
    chk("tmo err0 pulse", m0_err, 0);
    adv();

    do_reset();
    go('0, mk(1'b0, 32'h10, 3'd4, 0, 1'b1));
    chk("rstL enter", m1_gnt, 1);
    adv();
    rst = 1'b1;
    go(rd(32'h14, 3'd4), mk(1'b0, 32'h18, 3'd4, 0, 1'b1));
    chk("rstL locked", {m1_gnt, m0_gnt}, 2'b10);
    adv();
    rst = 1'b0;
    go(rd(32'h14, 3'd4), rd(32'h1C, 3'd4));
    chk("rstL conflict", {m1_gnt, m0_gnt}, 2'b01);
    chk("rstL rvalid", {m1_rvalid, m0_rvalid}, 0);
    chk("rstL rdata1", m1_rdata, 0);
    chk("rstL err", {m1_err, m0_err}, 0);
    adv();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
